// File: rtl/e203_irq_pkg.sv
// Shared types and constants for the E203 interrupt arbiter slice.
package e203_irq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BLOCK = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        BLOCK = ST_BLOCK
    } irq_state_e;

    localparam logic [3:0] IRQ_CAUSE_EXT = 4'd11;
    localparam logic [3:0] IRQ_CAUSE_SFT = 4'd3;
    localparam logic [3:0] IRQ_CAUSE_TMR = 4'd7;
    localparam logic [3:0] IRQ_CAUSE_DBG = 4'd0;

    // A maskable source counts only when locally and globally enabled and the core is not halted.
    function automatic logic irq_qual(input logic src, input logic en,
                                      input logic glb_en, input logic dbg_mode);
        return src & en & glb_en & ~dbg_mode;
    endfunction

endpackage

// File: rtl/e203_irq_arb_prio_enc.sv
// Fixed-priority encoder: dbg > ext > sft > tmr; qual is {dbg, ext, sft, tmr}.
module e203_irq_prio_enc
    import e203_irq_pkg::*;
(
    input  logic [3:0] qual,
    output logic       any,
    output logic       dbg,
    output logic [3:0] cause
);

    // Select the highest-priority qualified source.
    always_comb begin
        any   = |qual;
        dbg   = 1'b0;
        cause = IRQ_CAUSE_DBG;
        if (qual[3]) begin
            dbg   = 1'b1;
            cause = IRQ_CAUSE_DBG;
        end else if (qual[2]) begin
            cause = IRQ_CAUSE_EXT;
        end else if (qual[1]) begin
            cause = IRQ_CAUSE_SFT;
        end else if (qual[0]) begin
            cause = IRQ_CAUSE_TMR;
        end else begin
            cause = IRQ_CAUSE_DBG;
        end
    end

endmodule

// File: rtl/e203_irq_arb.sv
// Interrupt arbiter: qualifies synchronized IRQ levels, issues one held request, then holds off.
// Optional feature macro: E203_IRQ_EXT_EDGE_EN (sticky rising-edge capture for the external IRQ).
module e203_irq_arb
    import e203_irq_pkg::*;
#(
    parameter int HOLDOFF = 2,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_irq_r,
    input  logic       sft_irq_r,
    input  logic       tmr_irq_r,
    input  logic       dbg_irq_r,
    input  logic       mstatus_mie,
    input  logic       mie_meie,
    input  logic       mie_msie,
    input  logic       mie_mtie,
    input  logic       dbg_mode,
    output logic       irq_req_valid,
    input  logic       irq_req_ready,
    output logic       irq_req_dbg,
    output logic [3:0] irq_req_cause,
    output logic [2:0] irq_pend
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : {CNT_W{1'b0}};

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             valid_r;
    logic             dbg_r;
    logic [3:0]       cause_r;
    logic [2:0]       pend_r;
    logic             ext_src_s;
    logic [3:0]       qual_s;
    logic             any_s;
    logic             win_dbg_s;
    logic [3:0]       win_cause_s;
    logic             accept_s;

    assign accept_s = valid_r & irq_req_ready;

`ifdef E203_IRQ_EXT_EDGE_EN
    logic ext_prev_r;
    logic ext_edge_r;
    logic ext_rise_s;
    logic ext_acc_s;

    assign ext_rise_s = ext_irq_r & ~ext_prev_r;
    assign ext_acc_s  = accept_s & ~dbg_r & (cause_r == IRQ_CAUSE_EXT);

    // Sticky external edge: a new rising edge wins over a same-cycle clear so it is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_prev_r <= 1'b0;
            ext_edge_r <= 1'b0;
        end else begin
            ext_prev_r <= ext_irq_r;
            if (ext_rise_s) begin
                ext_edge_r <= 1'b1;
            end else if (ext_acc_s) begin
                ext_edge_r <= 1'b0;
            end else begin
                ext_edge_r <= ext_edge_r;
            end
        end
    end

    assign ext_src_s = ext_edge_r;
`else
    assign ext_src_s = ext_irq_r;
`endif

    assign qual_s = {dbg_irq_r & ~dbg_mode,
                     irq_qual(ext_src_s, mie_meie, mstatus_mie, dbg_mode),
                     irq_qual(sft_irq_r, mie_msie, mstatus_mie, dbg_mode),
                     irq_qual(tmr_irq_r, mie_mtie, mstatus_mie, dbg_mode)};

    e203_irq_prio_enc u_prio_enc (
        .qual  (qual_s),
        .any   (any_s),
        .dbg   (win_dbg_s),
        .cause (win_cause_s)
    );

    // Raw pending snapshot for mip readback.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= 3'b000;
        end else begin
            pend_r <= {ext_src_s, sft_irq_r, tmr_irq_r};
        end
    end

    // Request FSM; dbg/cause are captured only in IDLE so they stay frozen through REQ and BLOCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
            dbg_r   <= 1'b0;
            cause_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        state_r <= ST_REQ;
                        valid_r <= 1'b1;
                        dbg_r   <= win_dbg_s;
                        cause_r <= win_cause_s;
                    end
                end
                ST_REQ: begin
                    if (accept_s) begin
                        valid_r <= 1'b0;
                        if (HOLDOFF == 0) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_BLOCK;
                            cnt_r   <= HOLD_LOAD;
                        end
                    end
                end
                ST_BLOCK: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign irq_req_valid = valid_r;
    assign irq_req_dbg   = dbg_r;
    assign irq_req_cause = cause_r;
    assign irq_pend      = pend_r;

endmodule

// File: tb/tb_e203_irq_arb.sv
// Scoreboard bench for e203_irq_arb: HOLDOFF=2 instance plus a HOLDOFF=0 instance on shared inputs.
module tb_e203_irq_arb;

    logic clk;
    logic rst;
    logic ext_irq_r, sft_irq_r, tmr_irq_r, dbg_irq_r;
    logic mstatus_mie, mie_meie, mie_msie, mie_mtie, dbg_mode;
    logic irq_req_ready;

    logic       v2, d2, v0, d0;
    logic [3:0] c2, c0;
    logic [2:0] p2, p0;

    typedef struct {
        logic       sel;
        logic       v;
        logic       d;
        logic [3:0] c;
        logic       pchk;
        logic [2:0] p;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";
    logic  pend_en = 1'b1;

    e203_irq_arb #(.HOLDOFF(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ext_irq_r(ext_irq_r), .sft_irq_r(sft_irq_r), .tmr_irq_r(tmr_irq_r), .dbg_irq_r(dbg_irq_r),
        .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_msie(mie_msie), .mie_mtie(mie_mtie),
        .dbg_mode(dbg_mode),
        .irq_req_valid(v2), .irq_req_ready(irq_req_ready), .irq_req_dbg(d2),
        .irq_req_cause(c2), .irq_pend(p2)
    );

    e203_irq_arb #(.HOLDOFF(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst),
        .ext_irq_r(ext_irq_r), .sft_irq_r(sft_irq_r), .tmr_irq_r(tmr_irq_r), .dbg_irq_r(dbg_irq_r),
        .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_msie(mie_msie), .mie_mtie(mie_mtie),
        .dbg_mode(dbg_mode),
        .irq_req_valid(v0), .irq_req_ready(irq_req_ready), .irq_req_dbg(d0),
        .irq_req_cause(c0), .irq_pend(p0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Push the outputs expected after the next edge for the current inputs, then clock.
    task automatic cyc(input logic sel, input logic v, input logic d, input logic [3:0] c);
        exp_t e;
        e.sel  = sel;
        e.v    = v;
        e.d    = d;
        e.c    = c;
        e.pchk = pend_en;
        e.p    = rst ? 3'b000 : {ext_irq_r, sft_irq_r, tmr_irq_r};
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: pop one expectation per edge and compare the selected instance.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.sel == 1'b0) begin
                check({phase, ".valid"}, 8'(v2), 8'(mon_e.v));
                check({phase, ".dbg"},   8'(d2), 8'(mon_e.d));
                check({phase, ".cause"}, 8'(c2), 8'(mon_e.c));
                if (mon_e.pchk) check({phase, ".pend"}, 8'(p2), 8'(mon_e.p));
            end else begin
                check({phase, ".h0.valid"}, 8'(v0), 8'(mon_e.v));
                check({phase, ".h0.dbg"},   8'(d0), 8'(mon_e.d));
                check({phase, ".h0.cause"}, 8'(c0), 8'(mon_e.c));
                if (mon_e.pchk) check({phase, ".h0.pend"}, 8'(p0), 8'(mon_e.p));
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        {ext_irq_r, sft_irq_r, tmr_irq_r, dbg_irq_r} = 4'b0000;
        {mstatus_mie, mie_meie, mie_msie, mie_mtie, dbg_mode} = 5'b00000;
        irq_req_ready = 1'b0;

        phase = "reset";
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;

`ifdef E203_IRQ_EXT_EDGE_EN
        pend_en = 1'b0;
        phase = "edge_steady";
        mstatus_mie = 1'b1; mie_meie = 1'b1; ext_irq_r = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 4'd11);
        irq_req_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd11);
        irq_req_ready = 1'b0;
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 4'd11);

        phase = "edge_block";
        ext_irq_r = 1'b0; tmr_irq_r = 1'b1; mie_mtie = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 4'd7);
        irq_req_ready = 1'b1; tmr_irq_r = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'd7);
        irq_req_ready = 1'b0; ext_irq_r = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd7);
        ext_irq_r = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'd7);
        cyc(1'b0, 1'b1, 1'b0, 4'd11);
        irq_req_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd11);
        irq_req_ready = 1'b0;
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 4'd11);
`else
        phase = "tmr";
        tmr_irq_r = 1'b1; mie_mtie = 1'b1; mstatus_mie = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 4'd7);
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 4'd7);
        irq_req_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd7);
        irq_req_ready = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'd7);
        cyc(1'b0, 1'b0, 1'b0, 4'd7);
        cyc(1'b0, 1'b1, 1'b0, 4'd7);
        irq_req_ready = 1'b1; tmr_irq_r = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'd7);
        irq_req_ready = 1'b0; mie_mtie = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd7);

        phase = "rdy_idle";
        irq_req_ready = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 4'd7);
        irq_req_ready = 1'b0;

        phase = "prio";
        {ext_irq_r, sft_irq_r, tmr_irq_r} = 3'b111;
        {mie_meie, mie_msie, mie_mtie} = 3'b111;
        cyc(1'b0, 1'b1, 1'b0, 4'd11);
        cyc(1'b0, 1'b1, 1'b0, 4'd11);
        ext_irq_r = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 4'd11);
        cyc(1'b0, 1'b1, 1'b0, 4'd11);
        dbg_irq_r = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 4'd11);
        dbg_irq_r = 1'b0; irq_req_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd11);
        irq_req_ready = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'd11);
        cyc(1'b0, 1'b0, 1'b0, 4'd11);
        cyc(1'b0, 1'b1, 1'b0, 4'd3);
        irq_req_ready = 1'b1; sft_irq_r = 1'b0; tmr_irq_r = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'd3);
        irq_req_ready = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd3);

        phase = "dbg";
        dbg_irq_r = 1'b1; ext_irq_r = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 4'd0);
        irq_req_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        irq_req_ready = 1'b0; dbg_mode = 1'b1; sft_irq_r = 1'b1; tmr_irq_r = 1'b1;
        repeat (5) cyc(1'b0, 1'b0, 1'b1, 4'd0);

        phase = "gmask";
        dbg_mode = 1'b0; dbg_irq_r = 1'b0; mstatus_mie = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 4'd0);
        mstatus_mie = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 4'd11);

        phase = "rst_req";
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        {ext_irq_r, sft_irq_r, tmr_irq_r} = 3'b000;
        {mie_meie, mie_msie, mie_mtie} = 3'b000;
        cyc(1'b0, 1'b0, 1'b0, 4'd0);

        phase = "hold0";
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        rst = 1'b0; tmr_irq_r = 1'b1; mie_mtie = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 4'd7);
        irq_req_ready = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 4'd7);
        irq_req_ready = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 4'd7);
        irq_req_ready = 1'b1; tmr_irq_r = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 4'd7);
        irq_req_ready = 1'b0; mie_mtie = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 4'd7);
`endif

        phase = "end";
        k = 0;
        while (exp_q.size() > 0 && k < 10) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("drain", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
